// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and reset constants.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } ifu_state_t;

  localparam logic [31:0] RST_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request, stale-response dropping
// on redirect, and a held instruction slot toward the decoder.
module ifu
  import ifu_pkg::*;
#(
  parameter int                  DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0] RST_PC   = DATA_LEN'(RST_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                jump_flag,
  input  logic [DATA_LEN-1:0] jump_addr,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [DATA_LEN-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [DATA_LEN-1:0] PC,
  output logic [DATA_LEN-1:0] PC_S
);

  ifu_state_t          state_r;
  logic [DATA_LEN-1:0] fetch_pc_r;
  logic [DATA_LEN-1:0] pc_r;
  logic [31:0]         inst_r;
  logic                drop_r;
  logic                req_valid_r;
  logic                inst_valid_r;

  logic [DATA_LEN-1:0] pc_plus4_s;
  logic [DATA_LEN-1:0] jump_tgt_s;
  logic                jump_lsb_unused_s;

  // Single PC+4 adder feeds both the link value and the sequential next fetch address.
  assign pc_plus4_s        = pc_r + DATA_LEN'(32'd4);
  assign jump_tgt_s        = {jump_addr[DATA_LEN-1:2], 2'b00};
  assign jump_lsb_unused_s = ^jump_addr[1:0];

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = fetch_pc_r;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign PC             = pc_r;
  assign PC_S           = pc_plus4_s;

  // Fetch FSM with its address, instruction and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_REQ;
      fetch_pc_r   <= RST_PC;
      pc_r         <= RST_PC;
      inst_r       <= NOP_INST;
      drop_r       <= 1'b0;
      req_valid_r  <= 1'b1;
      inst_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (jump_flag) begin
            fetch_pc_r <= jump_tgt_s;
          end
          // A redirect racing the handshake makes the accepted request stale.
          if (imem_req_ready) begin
            pc_r        <= fetch_pc_r;
            drop_r      <= jump_flag;
            state_r     <= ST_WAIT;
            req_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (jump_flag) begin
            fetch_pc_r <= jump_tgt_s;
          end
          if (imem_rsp_valid) begin
            drop_r <= 1'b0;
            if (jump_flag || drop_r) begin
              state_r     <= ST_REQ;
              req_valid_r <= 1'b1;
            end else begin
              inst_r       <= imem_rdata;
              state_r      <= ST_HOLD;
              inst_valid_r <= 1'b1;
            end
          end else if (jump_flag) begin
            drop_r <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (jump_flag || inst_ready) begin
            fetch_pc_r   <= jump_flag ? jump_tgt_s : pc_plus4_s;
            state_r      <= ST_REQ;
            req_valid_r  <= 1'b1;
            inst_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_REQ;
          drop_r       <= 1'b0;
          req_valid_r  <= 1'b1;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit: outputs sampled on the falling edge and
// compared against hand-computed values.
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] PC;
  logic [31:0] PC_S;

  int n_assert;
  int n_fail;

  ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_flag      (jump_flag),
    .jump_addr      (jump_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .PC             (PC),
    .PC_S           (PC_S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    jump_flag      = 1'b0;
    jump_addr      = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = 32'h0;
    inst_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_pc", PC, 32'h8000_0000);
    chk("rst_pc_s", PC_S, 32'h8000_0004);

    // Release reset; first fetch with a 1-cycle response
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    chk("f0_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("f0_addr", imem_addr, 32'h8000_0000);
    tick();
    chk("f0_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("f0_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0000_0293;
    tick();
    imem_rsp_valid = 1'b0;
    chk("f0_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("f0_inst", inst, 32'h0000_0293);
    chk("f0_pc", PC, 32'h8000_0000);
    chk("f0_pc_s", PC_S, 32'h8000_0004);
    tick();

    // Back-to-back fetches
    chk("f1_addr", imem_addr, 32'h8000_0004);
    chk("f1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("f1_inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0040_0313;
    tick();
    imem_rsp_valid = 1'b0;
    chk("f1_inst", inst, 32'h0040_0313);
    chk("f1_pc", PC, 32'h8000_0004);
    tick();
    chk("f2_addr", imem_addr, 32'h8000_0008);
    tick();

    // Redirect while waiting: the next response is stale
    jump_flag = 1'b1;
    jump_addr = 32'h8000_1002;
    tick();
    jump_flag = 1'b0;
    chk("jw_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("jw_addr", imem_addr, 32'h8000_1000);
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("jw_stale_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("jw_stale_inst", inst, 32'h0040_0313);
    chk("jw_req_valid2", {31'd0, imem_req_valid}, 32'd1);
    chk("jw_addr2", imem_addr, 32'h8000_1000);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0050_0393;
    inst_ready     = 1'b0;
    tick();
    chk("jw_inst", inst, 32'h0050_0393);
    chk("jw_pc", PC, 32'h8000_1000);

    // Decoder stalls for 5 cycles; responses in HOLD are ignored
    imem_rdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h0050_0393);
      chk("hold_pc", PC, 32'h8000_1000);
      chk("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    chk("hold_next_addr", imem_addr, 32'h8000_1004);
    tick();

    // Redirect coincident with the response in WAIT
    jump_flag      = 1'b1;
    jump_addr      = 32'h8000_2000;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hAAAA_AAAA;
    tick();
    jump_flag      = 1'b0;
    imem_rsp_valid = 1'b0;
    chk("jr_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("jr_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("jr_addr", imem_addr, 32'h8000_2000);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0060_0413;
    tick();
    imem_rsp_valid = 1'b0;
    chk("jr_inst_valid2", {31'd0, inst_valid}, 32'd1);
    chk("jr_inst", inst, 32'h0060_0413);
    chk("jr_pc", PC, 32'h8000_2000);

    // Jump in HOLD takes priority even with inst_ready low
    inst_ready = 1'b0;
    jump_flag  = 1'b1;
    jump_addr  = 32'hFFFF_FFFC;
    tick();
    jump_flag  = 1'b0;
    chk("jh_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("jh_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0070_0493;
    tick();
    imem_rsp_valid = 1'b0;
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pc_s", PC_S, 32'h0000_0000);
    inst_ready = 1'b1;
    tick();
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Redirect coincident with the request handshake
    jump_flag = 1'b1;
    jump_addr = 32'h0000_0100;
    tick();
    jump_flag      = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0BAD_0BAD;
    tick();
    imem_rsp_valid = 1'b0;
    chk("jq_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("jq_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("jq_addr", imem_addr, 32'h0000_0100);
    tick();

    // Asynchronous reset during WAIT, then a late response
    imem_req_ready = 1'b0;
    chk("rw_pre_pc", PC, 32'h0000_0100);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rw_addr", imem_addr, 32'h8000_0000);
    chk("rw_pc", PC, 32'h8000_0000);
    chk("rw_inst", inst, 32'h0000_0013);
    @(negedge clk);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h5555_5555;
    tick();
    imem_rsp_valid = 1'b0;
    chk("rw_late_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rw_late_inst", inst, 32'h0000_0013);
    chk("rw_late_req_valid", {31'd0, imem_req_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
